// File: rtl/fft_sample_framer.sv
// Ping-pong sample framer: collects SAMPLES words per bank and presents a full
// bank to the FFT stage in bit-reversed order until the stage acknowledges it.
module fft_sample_framer #(
  parameter int SAMPLES = 4,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             frame_ack,
  output logic [WIDTH-1:0] frame_out [SAMPLES-1:0],
  output logic             frame_valid,
  output logic             overflow,
  output logic [15:0]      frame_count
);

  localparam int IDXW = $clog2(SAMPLES);

  logic [WIDTH-1:0] bank_q [2][SAMPLES];
  logic             wr_bank_q, wr_bank_d;
  logic [IDXW-1:0]  wr_idx_q, wr_idx_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      frame_count_q, frame_count_d;

  logic accept, ack_take, last;

  function automatic logic [IDXW-1:0] bitrev(input logic [IDXW-1:0] v);
    bitrev = '0;
    for (int unsigned b = 0; b < IDXW; b++) bitrev[b] = v[IDXW-1-b];
  endfunction

  // Accept and ack both look at pre-edge bank_full; they can never target the
  // same bank, so the two updates to bank_full_d never collide.
  always_comb begin
    accept        = sample_valid && !bank_full_q[wr_bank_q];
    ack_take      = frame_ack && bank_full_q[rd_bank_q];
    last          = (wr_idx_q == IDXW'(SAMPLES - 1));
    wr_bank_d     = wr_bank_q;
    wr_idx_d      = wr_idx_q;
    rd_bank_d     = rd_bank_q;
    bank_full_d   = bank_full_q;
    overflow_d    = overflow_q;
    frame_count_d = frame_count_q;
    if (accept) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (last) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = ~wr_bank_q;
      end
    end else if (sample_valid) begin
      overflow_d = 1'b1;
    end
    if (ack_take) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
      frame_count_d          = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      rd_bank_q     <= 1'b0;
      bank_full_q   <= '0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned i = 0; i < SAMPLES; i++)
          bank_q[b][i] <= '0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      wr_idx_q      <= wr_idx_d;
      rd_bank_q     <= rd_bank_d;
      bank_full_q   <= bank_full_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
      if (accept) bank_q[wr_bank_q][wr_idx_q] <= sample_in;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < SAMPLES; k++)
      frame_out[k] = bank_q[rd_bank_q][bitrev(IDXW'(k))];
  end

  assign frame_valid = bank_full_q[rd_bank_q];
  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fft_sample_framer.sv
// Directed bench for fft_sample_framer with SAMPLES=4, WIDTH=32.
module tb_fft_sample_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sample_in;
  logic        sample_valid;
  logic        frame_ack;
  logic [31:0] frame_out [3:0];
  logic        frame_valid;
  logic        overflow;
  logic [15:0] frame_count;

  int checks   = 0;
  int failures = 0;

  fft_sample_framer #(.SAMPLES(4), .WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .frame_ack    (frame_ack),
    .frame_out    (frame_out),
    .frame_valid  (frame_valid),
    .overflow     (overflow),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_frame(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
    check({tag, "[0]"}, frame_out[0], e0);
    check({tag, "[1]"}, frame_out[1], e1);
    check({tag, "[2]"}, frame_out[2], e2);
    check({tag, "[3]"}, frame_out[3], e3);
  endtask

  // One clock: drive inputs, take the edge, settle 1 time unit, idle inputs.
  task automatic cycle(input logic sv, input logic [31:0] sd, input logic ack);
    sample_valid = sv;
    sample_in    = sd;
    frame_ack    = ack;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    sample_in    = '0;
    frame_ack    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sample_valid = 1'b0; sample_in = '0; frame_ack = 1'b0;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    reset = 1'b0;
    check("rst_valid", {31'b0, frame_valid}, 0);
    check("rst_ovf", {31'b0, overflow}, 0);
    check("rst_count", {16'b0, frame_count}, 0);
    check_frame("rst_frame", 0, 0, 0, 0);

    // Basic fill
    cycle(1, 100, 0);
    cycle(1, 150, 0);
    cycle(1, 200, 0);
    check("fill_not_yet", {31'b0, frame_valid}, 0);
    cycle(1, 250, 0);
    check("fill_valid", {31'b0, frame_valid}, 1);
    check_frame("fill", 100, 200, 150, 250);

    // Second bank filled while first is held
    cycle(1, 1, 0);
    cycle(1, 2, 0);
    cycle(1, 3, 0);
    cycle(1, 4, 0);
    check_frame("hold", 100, 200, 150, 250);
    check("hold_count", {16'b0, frame_count}, 0);
    cycle(0, 0, 1);
    check("ack1_count", {16'b0, frame_count}, 1);
    check("ack1_valid", {31'b0, frame_valid}, 1);
    check_frame("pingpong", 1, 3, 2, 4);
    cycle(0, 0, 1);
    check("ack2_valid", {31'b0, frame_valid}, 0);
    check("ack2_count", {16'b0, frame_count}, 2);
    cycle(0, 0, 1);
    check("spur_count", {16'b0, frame_count}, 2);
    check("spur_valid", {31'b0, frame_valid}, 0);

    // Overflow
    for (int i = 0; i < 8; i++) cycle(1, 32'(10 + i), 0);
    check("pre_ovf", {31'b0, overflow}, 0);
    cycle(1, 999, 0);
    check("ovf_set", {31'b0, overflow}, 1);
    check_frame("ovf_bank0", 10, 12, 11, 13);
    cycle(0, 0, 1);
    check_frame("ovf_bank1", 14, 16, 15, 17);
    cycle(0, 0, 1);
    check("ovf_count", {16'b0, frame_count}, 4);
    for (int i = 0; i < 4; i++) cycle(1, 32'(20 + i), 0);
    check_frame("post_ovf", 20, 22, 21, 23);
    check("ovf_sticky", {31'b0, overflow}, 1);

    // Ack together with a sample aimed at a full bank: sample still dropped
    for (int i = 0; i < 4; i++) cycle(1, 32'(30 + i), 0);
    cycle(1, 777, 1);
    check("drop_ack_count", {16'b0, frame_count}, 5);
    check_frame("drop_ack", 30, 32, 31, 33);
    for (int i = 0; i < 4; i++) cycle(1, 32'(40 + i), 0);
    cycle(0, 0, 1);
    check_frame("no777", 40, 42, 41, 43);
    cycle(0, 0, 1);
    check("drain_count", {16'b0, frame_count}, 7);

    // Reset mid-frame, with sample and ack also asserted
    cycle(1, 50, 0);
    cycle(1, 51, 0);
    reset = 1'b1;
    cycle(1, 52, 1);
    reset = 1'b0;
    check("mrst_count", {16'b0, frame_count}, 0);
    check("mrst_valid", {31'b0, frame_valid}, 0);
    check("mrst_ovf", {31'b0, overflow}, 0);
    check_frame("mrst_zero", 0, 0, 0, 0);
    cycle(1, 5, 0);
    cycle(1, 6, 0);
    cycle(1, 7, 0);
    cycle(1, 8, 0);
    check_frame("mrst_frame", 5, 7, 6, 8);
    check("mrst_ovf2", {31'b0, overflow}, 0);
    check("mrst_count2", {16'b0, frame_count}, 0);

    // Ack on the same edge as the last sample of the other bank
    cycle(1, 60, 0);
    cycle(1, 61, 0);
    cycle(1, 62, 0);
    cycle(1, 63, 1);
    check("sim_count", {16'b0, frame_count}, 1);
    check("sim_valid", {31'b0, frame_valid}, 1);
    check_frame("sim_frame", 60, 62, 61, 63);
    cycle(0, 0, 1);
    check("sim_drain_valid", {31'b0, frame_valid}, 0);
    check("sim_drain_count", {16'b0, frame_count}, 2);
    cycle(0, 0, 1);
    check("sim_spur_count", {16'b0, frame_count}, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
